hamming_counter: RTL and testbench

HAMMING_COUNTER -- requirements
Module: hamming_counter

---
 rtl/hamming_pkg.sv | 15 +
 rtl/hamming_counter_popcount_slice.sv | 21 ++
 rtl/hamming_counter.sv | 116 +++++++++++
 tb/tb_hamming_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming-distance popcount block:
// FSM encoding, default geometry and running-total width.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N   = 32;
    localparam int DEF_BPC = 4;
    localparam int ACC_W   = 16;

endpackage

// File: rtl/hamming_counter_popcount_slice.sv
// Combinational popcount of one W-bit slice of the
// shifted XOR word.
module popcount_slice
    import hamming_pkg::*;
#(
    parameter int W  = DEF_BPC,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [CW-1:0] o_count
);

    // Add up the set bits of the slice
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/hamming_counter.sv
// Multi-cycle popcount of an XOR word, BPC bits per clock,
// with valid/ready on both sides and a saturating total.
module hamming_counter
    import hamming_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int BPC = DEF_BPC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [$clog2(N+1)-1:0] out_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr,
    output logic [ACC_W-1:0]       acc_total,
    output logic                   busy
);

    localparam int CW    = $clog2(N + 1);
    localparam int BEATS = N / BPC;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(BPC + 1);
    localparam int AW1   = ACC_W + 1;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_shift;
    logic [BW-1:0]    r_beat;
    logic [CW-1:0]    r_part;
    logic [CW-1:0]    r_count;
    logic [ACC_W-1:0] r_acc;
    logic [CW-1:0]    w_sum;
    logic [PW-1:0]    w_pop;
    logic [AW1-1:0]   w_acc_sum;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_last;

    popcount_slice #(
        .W  (BPC),
        .CW (PW)
    ) u_pop (
        .i_bits  (r_shift[BPC-1:0]),
        .o_count (w_pop)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_count = r_count;
    assign acc_total = r_acc;

    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    assign w_last    = (r_beat == BW'(BEATS - 1));
    assign w_sum     = r_part + CW'(w_pop);
    assign w_acc_sum = {1'b0, r_acc} + AW1'(r_count);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: accept, count the beats, wait for consumer
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_in_hs)  w_next = COUNT;
            COUNT:   if (w_last)   w_next = DONE;
            DONE:    if (w_out_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shift register, beat counter, partial and final count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_beat  <= '0;
            r_part  <= '0;
            r_count <= '0;
        end else if (w_in_hs) begin
            r_shift <= in_data;
            r_beat  <= '0;
            r_part  <= '0;
        end else if (r_state == COUNT) begin
            r_shift <= r_shift >> BPC;
            r_beat  <= r_beat + BW'(1);
            r_part  <= w_sum;
            if (w_last) begin
                r_count <= w_sum;
            end
        end
    end

    // Saturating total; a clear still keeps the word handed off now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr && w_out_hs) begin
            r_acc <= ACC_W'(r_count);
        end else if (clr) begin
            r_acc <= '0;
        end else if (w_out_hs) begin
            r_acc <= w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
        end
    end

endmodule

// File: tb/tb_hamming_counter.sv
// Directed and random checks of hamming_counter against a
// word-level popcount / saturating-sum reference model.
module tb_hamming_counter;

    localparam int N     = 32;
    localparam int BEATS = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    out_count;
    logic          out_valid;
    logic          out_ready;
    logic          clr;
    logic [15:0]   acc_total;
    logic          busy;

    int n_vec;
    int n_err;
    int acc_m;

    hamming_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr       (clr),
        .acc_total (acc_total),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        acc_m = 0;
        check("clr_acc", acc_total, 0);
    endtask

    task automatic run_word(input logic [N-1:0] d, input int hold,
                            input bit vhold, input bit clr_hs);
        int cyc;
        int pc;
        pc = $countones(d);
        check("in_ready_idle", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = vhold;
        check("busy_count", busy, 1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", cyc, BEATS);
        check("out_count", out_count, pc);
        check("in_ready_done", in_ready, 0);
        if (hold > 0) begin
            repeat (hold) tick();
            check("hold_count", out_count, pc);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        clr       = clr_hs;
        tick();
        out_ready = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        if (clr_hs) acc_m = pc;
        else acc_m = (acc_m + pc > 65535) ? 65535 : acc_m + pc;
        check("acc_total", acc_total, acc_m);
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
        check("count_kept", out_count, pc);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        acc_m     = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_count", out_count, 0);
        check("rst_acc", acc_total, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);

        run_word(32'hCF075530, 0, 1'b0, 1'b0);
        check("word_acc15", acc_total, 15);

        do_clr();
        run_word(32'hFFFFFFFF, 0, 1'b0, 1'b0);
        run_word(32'h00000000, 0, 1'b0, 1'b0);
        check("extreme_acc", acc_total, 32);

        run_word(32'hA5A5_0F0F, 5, 1'b1, 1'b0);

        do_clr();
        run_word(32'hFFFFFFFF, 0, 1'b0, 1'b0);
        run_word(32'h000000FF, 0, 1'b0, 1'b0);
        check("acc40", acc_total, 40);
        run_word(32'hCF075530, 0, 1'b0, 1'b1);
        check("clr_hs_acc", acc_total, 15);

        for (int i = 0; i < 30; i++) begin
            run_word($urandom, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        acc_m = 0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_acc", acc_total, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_ready", in_ready, 1);
        check("rel_acc", acc_total, 0);
        run_word(32'h0000_F00F, 0, 1'b0, 1'b0);

        do_clr();
        for (int i = 0; i < 2048; i++) begin
            run_word(32'hFFFFFFFF, 0, 1'b0, 1'b0);
        end
        check("sat_acc", acc_total, 16'hFFFF);
        run_word(32'hFFFFFFFF, 0, 1'b0, 1'b0);
        check("sat_hold", acc_total, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
